// File: rtl/cp_remove_pkg.sv
// Shared constants and types for the cyclic-prefix remover.
package cp_remove_pkg;

    localparam int unsigned N_FFT_DEF  = 512;
    localparam int unsigned CP_LEN_DEF = 32;
    localparam int unsigned DW_DEF     = 12;
    localparam int unsigned SYM_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        PASS = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cp_remove.sv
// Strips the cyclic prefix from each OFDM symbol of a frame and forwards the
// N_FFT useful samples to the FFT with symbol index and end-of-symbol marks.
module cp_remove
    import cp_remove_pkg::*;
#(
    parameter int unsigned N_FFT  = N_FFT_DEF,
    parameter int unsigned CP_LEN = CP_LEN_DEF,
    parameter int unsigned DW     = DW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             new_frame,
    input  logic [SYM_W-1:0] sym_num,
    input  logic [DW-1:0]    di_re,
    input  logic [DW-1:0]    di_im,
    input  logic             di_vld,
    output logic [DW-1:0]    do_re,
    output logic [DW-1:0]    do_im,
    output logic             do_vld,
    output logic             do_last,
    output logic [SYM_W-1:0] do_sym_idx,
    output logic             frame_done
);

    localparam int unsigned CW  = cnt_width(N_FFT);
    localparam int unsigned SW1 = SYM_W + 1;

    localparam logic [CW-1:0] CP_LAST  = CW'(CP_LEN - 1);
    localparam logic [CW-1:0] FFT_LAST = CW'(N_FFT - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [SYM_W-1:0] sym_lat;

    // Frame FSM, sample/symbol counters and output register in one process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sym_lat    <= SYM_W'(1);
            do_re      <= '0;
            do_im      <= '0;
            do_vld     <= 1'b0;
            do_last    <= 1'b0;
            do_sym_idx <= '0;
            frame_done <= 1'b0;
        end else begin
            do_vld     <= 1'b0;
            do_last    <= 1'b0;
            frame_done <= 1'b0;

            if (new_frame) begin
                // Frame start wins over any sample in the same cycle and aborts a running frame.
                state      <= SKIP;
                cnt        <= '0;
                do_sym_idx <= '0;
                sym_lat    <= (sym_num == '0) ? SYM_W'(1) : sym_num;
            end else begin
                case (state)
                    IDLE: ;
                    SKIP: begin
                        // Index advances as do_last of the previous symbol drops.
                        if (do_last) begin
                            do_sym_idx <= do_sym_idx + SYM_W'(1);
                        end
                        if (di_vld) begin
                            if (cnt == CP_LAST) begin
                                cnt   <= '0;
                                state <= PASS;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    PASS: begin
                        if (di_vld) begin
                            do_re  <= di_re;
                            do_im  <= di_im;
                            do_vld <= 1'b1;
                            if (cnt == FFT_LAST) begin
                                do_last <= 1'b1;
                                cnt     <= '0;
                                if ((SW1'(do_sym_idx) + SW1'(1)) < SW1'(sym_lat)) begin
                                    state <= SKIP;
                                end else begin
                                    state <= DONE;
                                end
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    DONE: begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp_remove.sv
// Scoreboard bench for cp_remove: expected samples are queued as they are driven
// and matched against the output stream, along with frame_done timing.
module tb_cp_remove;

    localparam int NS = 544;
    localparam int CP = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_frame = 1'b0;
    logic [3:0]  sym_num = '0;
    logic [11:0] di_re = '0;
    logic [11:0] di_im = '0;
    logic        di_vld = 1'b0;
    logic [11:0] do_re;
    logic [11:0] do_im;
    logic        do_vld;
    logic        do_last;
    logic [3:0]  do_sym_idx;
    logic        frame_done;

    typedef struct {
        logic [11:0] re;
        logic [11:0] im;
        logic        last;
        logic [3:0]  idx;
        logic        fin;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fd_cnt = 0;
    bit fd_due = 1'b0;

    int m_i = 0;
    int m_nsym = 1;
    bit m_on = 1'b0;

    cp_remove dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_frame  (new_frame),
        .sym_num    (sym_num),
        .di_re      (di_re),
        .di_im      (di_im),
        .di_vld     (di_vld),
        .do_re      (do_re),
        .do_im      (do_im),
        .do_vld     (do_vld),
        .do_last    (do_last),
        .do_sym_idx (do_sym_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every do_vld, checks frame_done placement.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (frame_done || fd_due) chk("frame_done", 32'(frame_done), 32'(fd_due));
            if (frame_done) fd_cnt++;
            fd_due = 1'b0;
            if (do_vld) begin
                if (sb.size() == 0) begin
                    chk("spurious_vld", 32'(do_vld), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("do_re", 32'(do_re), 32'(e.re));
                    chk("do_im", 32'(do_im), 32'(e.im));
                    chk("do_last", 32'(do_last), 32'(e.last));
                    chk("do_sym_idx", 32'(do_sym_idx), 32'(e.idx));
                    chk("latency", 32'(cyc), 32'(e.cyc));
                    fd_due = e.fin;
                end
            end else if (do_last) begin
                chk("last_wo_vld", 32'(do_last), 32'(0));
            end
        end else begin
            fd_due = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] n, input bit with_vld);
        new_frame = 1'b1;
        sym_num   = n;
        di_vld    = with_vld;
        di_re     = 12'hABC;
        di_im     = 12'h543;
        tick();
        new_frame = 1'b0;
        di_vld    = 1'b0;
        m_on      = 1'b1;
        m_i       = 0;
        m_nsym    = (n == 4'd0) ? 1 : int'(n);
    endtask

    task automatic send(input int count, input bit gap);
        exp_t e;
        int p;
        int k;
        for (int s = 0; s < count; s++) begin
            di_vld = 1'b1;
            di_re  = 12'(m_i);
            di_im  = ~12'(m_i);
            if (m_on && m_i < m_nsym * NS) begin
                p = m_i % NS;
                k = m_i / NS;
                if (p >= CP) begin
                    e.re   = 12'(m_i);
                    e.im   = ~12'(m_i);
                    e.last = (p == NS - 1);
                    e.idx  = 4'(k);
                    e.fin  = (p == NS - 1) && (k == m_nsym - 1);
                    e.cyc  = cyc + 1;
                    sb.push_back(e);
                end
                m_i++;
            end
            tick();
            di_vld = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic drain;
        for (int c = 0; c < 200 && sb.size() > 0; c++) tick();
        repeat (4) tick();
        chk("drain", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #22;
        chk("rst_vld", 32'(do_vld), 32'(0));
        chk("rst_re", 32'(do_re), 32'(0));
        chk("rst_last", 32'(do_last), 32'(0));
        chk("rst_idx", 32'(do_sym_idx), 32'(0));
        chk("rst_done", 32'(frame_done), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Samples before any frame start must be ignored.
        send(20, 1'b0);
        drain();

        // Six contiguous symbols.
        start(4'd6, 1'b0);
        send(6 * NS, 1'b0);
        drain();
        chk("fd_count_ramp", 32'(fd_cnt), 32'(1));

        // Same frame with alternating valid gaps.
        start(4'd6, 1'b0);
        send(6 * NS, 1'b1);
        drain();
        chk("fd_count_gap", 32'(fd_cnt), 32'(2));

        // Single symbol frame.
        start(4'd1, 1'b0);
        send(NS, 1'b0);
        drain();
        chk("fd_count_one", 32'(fd_cnt), 32'(3));

        // sym_num of zero behaves as one.
        start(4'd0, 1'b0);
        send(NS, 1'b0);
        drain();
        chk("fd_count_zero", 32'(fd_cnt), 32'(4));

        // Abort at sample 300 of symbol 2 with a sample in the same cycle, then a fresh frame.
        start(4'd6, 1'b0);
        send(2 * NS + 300, 1'b0);
        start(4'd1, 1'b1);
        send(NS, 1'b0);
        drain();
        chk("fd_count_abort", 32'(fd_cnt), 32'(5));

        // Extra samples after frame_done are dropped.
        send(100, 1'b0);
        drain();

        // Asynchronous reset in the middle of a passing symbol.
        start(4'd2, 1'b0);
        send(200, 1'b0);
        drain();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(do_vld), 32'(0));
        chk("arst_re", 32'(do_re), 32'(0));
        chk("arst_im", 32'(do_im), 32'(0));
        chk("arst_last", 32'(do_last), 32'(0));
        chk("arst_idx", 32'(do_sym_idx), 32'(0));
        chk("arst_done", 32'(frame_done), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_on  = 1'b0;
        #1;
        send(600, 1'b0);
        drain();
        chk("fd_count_end", 32'(fd_cnt), 32'(5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
